// File: rtl/fetch_control_pkg.sv
// Shared types and constants for the instruction-fetch sequencing controller.
package fetch_control_pkg;

   // Controller states; reset enters BOOT.
   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } fc_state_e;

   // Register $0 is hard-wired to zero, so a load into it can never create a hazard.
   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses, holds at all-ones.
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: increment unless already saturated.
   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) begin
         count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Count register, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/fetch_control.sv
// Fetch-stage sequencing controller: boot hold, load-use stall, redirect,
// imem wait and halt handling, plus stall/flush performance counters.
module fetch_control
   import fetch_control_pkg::*;
#(
   parameter int unsigned BOOT_CYCLES = 4,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inMemRead_EX,
   input  logic [4:0]       inRt_EX,
   input  logic [4:0]       inRs_ID,
   input  logic [4:0]       inRt_ID,
   input  logic             inBranchTaken,
   input  logic             inJump_ID,
   input  logic             inHalt_ID,
   input  logic             inImemReady,
   output logic             outPCWrite,
   output logic             outIF_IDWrite,
   output logic             outIF_Flush,
   output logic             outPCSrc,
   output logic             outJump,
   output logic             outBubble,
   output logic             outHalted,
   output logic [CNT_W-1:0] outStallCnt,
   output logic [CNT_W-1:0] outFlushCnt
);

   localparam logic [7:0] BOOT_LAST = 8'(BOOT_CYCLES - 1);

   fc_state_e  state_q, state_d;
   logic [7:0] boot_cnt_q, boot_cnt_d;
   logic       load_use;
   logic       stall_inc;
   logic       flush_inc;

   // Load-use hazard: the EX load writes a register the ID instruction reads.
   always_comb begin
      load_use = inMemRead_EX && (inRt_EX != REG_ZERO) &&
                 ((inRt_EX == inRs_ID) || (inRt_EX == inRt_ID));
   end

   // Control outputs and next state; outputs are combinational so the fetch
   // datapath consumes them at the same edge.
   always_comb begin
      outPCWrite    = 1'b0;
      outIF_IDWrite = 1'b1;
      outIF_Flush   = 1'b1;
      outPCSrc      = 1'b0;
      outJump       = 1'b0;
      outBubble     = 1'b0;
      outHalted     = 1'b0;
      stall_inc     = 1'b0;
      flush_inc     = 1'b0;
      state_d       = state_q;
      boot_cnt_d    = boot_cnt_q;

      unique case (state_q)
         RUN: begin
            if (load_use) begin
               outIF_IDWrite = 1'b0;
               outIF_Flush   = 1'b0;
               outBubble     = 1'b1;
               stall_inc     = 1'b1;
            end else if (inHalt_ID) begin
               state_d = HALTED;
            end else if (inJump_ID || inBranchTaken) begin
               outPCWrite = 1'b1;
               outJump    = inJump_ID;
               outPCSrc   = inBranchTaken & ~inJump_ID;
               flush_inc  = 1'b1;
            end else if (!inImemReady) begin
               stall_inc = 1'b1;
            end else begin
               outPCWrite  = 1'b1;
               outIF_Flush = 1'b0;
            end
         end
         HALTED: begin
            outHalted = 1'b1;
         end
         default: begin
            // BOOT (and the unused encoding, which recovers through BOOT).
            boot_cnt_d = boot_cnt_q + 8'd1;
            if (state_q != BOOT) begin
               state_d    = BOOT;
               boot_cnt_d = '0;
            end else if (boot_cnt_q == BOOT_LAST) begin
               state_d = RUN;
            end
         end
      endcase
   end

   // State and boot counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= BOOT;
         boot_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         boot_cnt_q <= boot_cnt_d;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_inc),
      .count (outStallCnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (flush_inc),
      .count (outFlushCnt)
   );

endmodule

// File: tb/tb_fetch_control.sv
// Directed bench for fetch_control with hand-computed expectations.
module tb_fetch_control;

   logic        clk;
   logic        rst_n;
   logic        inMemRead_EX;
   logic [4:0]  inRt_EX;
   logic [4:0]  inRs_ID;
   logic [4:0]  inRt_ID;
   logic        inBranchTaken;
   logic        inJump_ID;
   logic        inHalt_ID;
   logic        inImemReady;
   logic        outPCWrite;
   logic        outIF_IDWrite;
   logic        outIF_Flush;
   logic        outPCSrc;
   logic        outJump;
   logic        outBubble;
   logic        outHalted;
   logic [15:0] outStallCnt;
   logic [15:0] outFlushCnt;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   fetch_control #(.BOOT_CYCLES(4), .CNT_W(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .inMemRead_EX  (inMemRead_EX),
      .inRt_EX       (inRt_EX),
      .inRs_ID       (inRs_ID),
      .inRt_ID       (inRt_ID),
      .inBranchTaken (inBranchTaken),
      .inJump_ID     (inJump_ID),
      .inHalt_ID     (inHalt_ID),
      .inImemReady   (inImemReady),
      .outPCWrite    (outPCWrite),
      .outIF_IDWrite (outIF_IDWrite),
      .outIF_Flush   (outIF_Flush),
      .outPCSrc      (outPCSrc),
      .outJump       (outJump),
      .outBubble     (outBubble),
      .outHalted     (outHalted),
      .outStallCnt   (outStallCnt),
      .outFlushCnt   (outFlushCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic mr, input logic [4:0] rt_ex, input logic [4:0] rs_id,
                        input logic [4:0] rt_id, input logic br, input logic jmp,
                        input logic hlt, input logic rdy);
      inMemRead_EX  = mr;
      inRt_EX       = rt_ex;
      inRs_ID       = rs_id;
      inRt_ID       = rt_id;
      inBranchTaken = br;
      inJump_ID     = jmp;
      inHalt_ID     = hlt;
      inImemReady   = rdy;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   // Advance past the next rising edge; sample point is 1 time unit later.
   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   // Expects to be called 2 units after reset release, mid-cycle 0 of BOOT.
   task automatic boot_seq(input string tag);
      for (int i = 0; i < 4; i++) begin
         chk({tag, "_boot_pcw"}, 32'(outPCWrite), 32'd0);
         chk({tag, "_boot_flush"}, 32'(outIF_Flush), 32'd1);
         chk({tag, "_boot_ifid"}, 32'(outIF_IDWrite), 32'd1);
         next_cyc();
      end
      chk({tag, "_run_pcw"}, 32'(outPCWrite), 32'd1);
      chk({tag, "_run_flush"}, 32'(outIF_Flush), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      #3;
      chk("rst_pcw", 32'(outPCWrite), 32'd0);
      chk("rst_ifid", 32'(outIF_IDWrite), 32'd1);
      chk("rst_flush", 32'(outIF_Flush), 32'd1);
      chk("rst_bubble", 32'(outBubble), 32'd0);
      chk("rst_halted", 32'(outHalted), 32'd0);
      chk("rst_stallcnt", 32'(outStallCnt), 32'd0);
      chk("rst_flushcnt", 32'(outFlushCnt), 32'd0);

      // Release between edges, then walk the 4-cycle boot hold.
      #9 rst_n = 1'b1;
      #2;
      boot_seq("b1");

      // Load-use via Rs: one-cycle stall.
      drive(1'b1, 5'd5, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1);
      #1;
      chk("lu_pcw", 32'(outPCWrite), 32'd0);
      chk("lu_ifid", 32'(outIF_IDWrite), 32'd0);
      chk("lu_bubble", 32'(outBubble), 32'd1);
      chk("lu_flush", 32'(outIF_Flush), 32'd0);
      next_cyc();
      idle();
      #1;
      chk("lu_after_pcw", 32'(outPCWrite), 32'd1);
      chk("lu_stallcnt", 32'(outStallCnt), 32'd1);

      // Load into $0: no hazard.
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      #1;
      chk("r0_pcw", 32'(outPCWrite), 32'd1);
      chk("r0_bubble", 32'(outBubble), 32'd0);
      next_cyc();
      chk("r0_stallcnt", 32'(outStallCnt), 32'd1);

      // Hazard via Rt, with imem wait and jump in the same cycle: hazard wins.
      drive(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0);
      #1;
      chk("luw_pcw", 32'(outPCWrite), 32'd0);
      chk("luw_jump", 32'(outJump), 32'd0);
      chk("luw_flush", 32'(outIF_Flush), 32'd0);
      chk("luw_bubble", 32'(outBubble), 32'd1);
      next_cyc();
      idle();
      #1;
      chk("luw_stallcnt", 32'(outStallCnt), 32'd2);
      chk("luw_flushcnt", 32'(outFlushCnt), 32'd0);

      // Jump and branch together: jump wins.
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
      #1;
      chk("jb_jump", 32'(outJump), 32'd1);
      chk("jb_pcsrc", 32'(outPCSrc), 32'd0);
      chk("jb_flush", 32'(outIF_Flush), 32'd1);
      chk("jb_pcw", 32'(outPCWrite), 32'd1);
      next_cyc();
      // Branch alone.
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      #1;
      chk("jb_flushcnt", 32'(outFlushCnt), 32'd1);
      chk("br_pcsrc", 32'(outPCSrc), 32'd1);
      chk("br_jump", 32'(outJump), 32'd0);
      next_cyc();
      idle();
      #1;
      chk("br_flushcnt", 32'(outFlushCnt), 32'd2);

      // Three imem wait cycles.
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
         #1;
         chk("wait_pcw", 32'(outPCWrite), 32'd0);
         chk("wait_flush", 32'(outIF_Flush), 32'd1);
         next_cyc();
      end
      chk("wait_stallcnt", 32'(outStallCnt), 32'd5);
      chk("wait_flushcnt", 32'(outFlushCnt), 32'd2);

      // Jump during the wait redirects anyway.
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      #1;
      chk("wj_pcw", 32'(outPCWrite), 32'd1);
      chk("wj_jump", 32'(outJump), 32'd1);
      next_cyc();
      chk("wj_flushcnt", 32'(outFlushCnt), 32'd3);
      chk("wj_stallcnt", 32'(outStallCnt), 32'd5);

      // Drive the stall counter to saturation: 5 + 65530 = 16'hFFFF.
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 65530; i++) begin
         @(posedge clk);
      end
      #1;
      chk("sat_reach", 32'(outStallCnt), 32'h0000_FFFF);
      next_cyc();
      chk("sat_hold", 32'(outStallCnt), 32'h0000_FFFF);
      chk("sat_flushcnt", 32'(outFlushCnt), 32'd3);

      // Halt: flush this cycle, HALTED from the next, jumps then ignored.
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      #1;
      chk("h_pcw", 32'(outPCWrite), 32'd0);
      chk("h_flush", 32'(outIF_Flush), 32'd1);
      chk("h_halted_now", 32'(outHalted), 32'd0);
      next_cyc();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("h_halted", 32'(outHalted), 32'd1);
         chk("h_hold_pcw", 32'(outPCWrite), 32'd0);
         next_cyc();
      end
      chk("h_flushcnt", 32'(outFlushCnt), 32'd3);

      // Reset pulse out of HALTED: immediate return to BOOT.
      idle();
      #1 rst_n = 1'b0;
      #1;
      chk("r2_halted", 32'(outHalted), 32'd0);
      chk("r2_pcw", 32'(outPCWrite), 32'd0);
      chk("r2_flush", 32'(outIF_Flush), 32'd1);
      chk("r2_stallcnt", 32'(outStallCnt), 32'd0);
      chk("r2_flushcnt", 32'(outFlushCnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #2;
      boot_seq("b2");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_control.md
# fetch_control

Sequencing controller for the instruction-fetch stage. Each cycle it drives the PC-write enable, the IF/ID write enable and flush, and the PC-source and jump select lines of the fetch datapath. It resolves load-use hazards, branch/jump redirects, instruction-memory wait states, a post-reset boot hold and a halt condition. It sits beside the fetch stage, takes hazard and decode information from ID/EX, and keeps saturating performance counters for stalls and flushes.

## Interface
- BOOT_CYCLES, default 4: cycles after reset release during which fetch is held; legal range 1..255.
- CNT_W, default 16: width of each performance counter.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- inMemRead_EX  in  1  instruction in ID/EX is a load.
- inRt_EX  in  5  destination register of the ID/EX load.
- inRs_ID, inRt_ID  in  5 each  source registers of the IF/ID instruction.
- inBranchTaken  in  1  branch in ID resolved taken this cycle.
- inJump_ID  in  1  unconditional jump decoded in ID.
- inHalt_ID  in  1  halt instruction decoded in ID.
- inImemReady  in  1  instruction memory output valid this cycle.
- outPCWrite  out  1  PC register load enable.
- outIF_IDWrite  out  1  IF/ID latch load enable.
- outIF_Flush  out  1  IF/ID latch clears to NOP.
- outPCSrc  out  1  1 selects the branch-target adder output.
- outJump  out  1  1 selects the jump target.
- outBubble  out  1  zeroes ID/EX control (stall bubble).
- outHalted  out  1  controller is in HALTED.
- outStallCnt, outFlushCnt  out  CNT_W each  saturating event counters.

## Operation
- States: BOOT, RUN, HALTED; 2-bit encoding; reset state is BOOT with the boot counter at 0.
- BOOT: outPCWrite=0, outIF_IDWrite=1, outIF_Flush=1, and all other outputs are 0. The boot counter increments each cycle. When the counter reaches BOOT_CYCLES-1, the next state is RUN. All ID inputs are ignored.
- RUN: control outputs are combinational from the inputs. Priority is highest first:
  1. Load-use hazard: inMemRead_EX and inRt_EX≠0 and (inRt_EX==inRs_ID or inRt_EX==inRt_ID). Response: outPCWrite=0, outIF_IDWrite=0, outBubble=1, outIF_Flush=0, and outStallCnt increments. The hazard suppresses any redirect or halt in the same cycle.
  2. Halt: inHalt_ID. Response: outPCWrite=0, outIF_Flush=1, and the next state is HALTED.
  3. Redirect: inJump_ID or inBranchTaken. Response: outPCWrite=1, outIF_Flush=1, and outFlushCnt increments. outJump=inJump_ID and outPCSrc=inBranchTaken&~inJump_ID, so jump wins over branch. The redirect takes effect even when inImemReady=0.
  4. Imem wait: ~inImemReady. Response: outPCWrite=0, outIF_IDWrite=1, outIF_Flush=1, and outStallCnt increments.
  5. Otherwise: outPCWrite=1 and outIF_IDWrite=1, with all other outputs 0.
- Outside the load-use case, outIF_IDWrite=1.
- HALTED: same outputs as BOOT, plus outHalted=1. The only exit is rst_n.
- Counters: both are 0 at reset and saturate at 2^CNT_W−1 with no wrap. A flush caused by halt or imem wait does not increment outFlushCnt.

## Timing
- Every control output is combinational from the current state and inputs and is consumed at the same clock edge: zero-cycle latency.
- State and counters are registered, so a counter is visible one cycle after its event.
- A load-use stall lasts exactly one cycle, because the load advances out of EX.
- During reset (rst_n=0), asynchronously: outPCWrite=0, outIF_IDWrite=1, outIF_Flush=1, outPCSrc=0, outJump=0, outBubble=0, outHalted=0, counters 0, state BOOT.
- Reset asserted mid-operation, including in HALTED, returns the block to BOOT immediately. The first PC increment occurs at the edge ending cycle BOOT_CYCLES after release.
- Simultaneous hazard + imem wait: the hazard outputs apply, and outStallCnt increments once.

## Structure
- Shared package: state enum (BOOT, RUN, HALTED) and the constant REG_ZERO=5'd0.
- One natural sub-module: sat_counter (parameter CNT_W; ports inc, count), instantiated twice.
- Everything else is flat: the hazard compare, priority logic and boot counter.

## Test plan
- Reset release with BOOT_CYCLES=4 and inImemReady=1: outPCWrite=0 for 4 cycles, then 1; outIF_Flush=1 throughout BOOT.
- In RUN, inMemRead_EX=1, inRt_EX=5, inRs_ID=5: exactly one cycle of outPCWrite=0, outIF_IDWrite=0, outBubble=1; outStallCnt=1 on the next cycle.
- Same hazard with inRt_EX=0: no stall; outPCWrite=1.
- inBranchTaken=1 and inJump_ID=1 together: outJump=1, outPCSrc=0, outIF_Flush=1, outFlushCnt+1. Branch alone: outPCSrc=1, outJump=0.
- inImemReady=0 for 3 cycles: outPCWrite=0 and outIF_Flush=1 in each; outStallCnt=3. A jump during the wait gives outPCWrite=1.
- inHalt_ID=1: outHalted=1 from the next cycle and outPCWrite stays 0 for 10 cycles. Pulsing rst_n low returns to BOOT. Preload outStallCnt to 16'hFFFF, then trigger a stall: the count stays at FFFF.
